// File: rtl/acqbuf_ctrl.sv
// rtl/acqbuf_ctrl.sv - acquisition buffer write controller
// One-shot fill or circular capture with trigger, decimation and post-trigger count.
module acqbuf_ctrl #(
  parameter int NCH  = 2,
  parameter int DW   = 64,
  parameter int AW   = 12,
  parameter int DECW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH*DW-1:0]   data_in,
  input  logic                start,
  input  logic                mode,
  input  logic                trig,
  input  logic [AW-1:0]       posttrig,
  input  logic [DECW-1:0]     decim,
  output logic [AW-1:0]       addr,
  output logic [NCH*DW-1:0]   data,
  output logic [NCH-1:0]      we,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       trig_addr,
  output logic                wrapped
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DECW-1:0]     decim_q;
  logic [DECW-1:0]     dec_cnt;
  logic [AW-1:0]       posttrig_q;
  logic [AW-1:0]       remain;
  logic [AW-1:0]       wr_ptr;
  logic                active;
  logic                slot;
  logic                last_addr;

  // first pipeline stage: slot flag, its address and the sampled input word
  logic                s1_valid;
  logic [AW-1:0]       s1_addr;
  logic [NCH*DW-1:0]   s1_data;

  always_comb begin
    active    = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
    // a start cycle never writes, so a restart cannot leak one stale slot
    slot      = active && (dec_cnt == '0) && !start;
    last_addr = (wr_ptr == '1);
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = mode ? S_ARMED : S_FILL;
    end else if (slot) begin
      case (state)
        S_FILL: begin
          if (last_addr) state_nxt = S_DONE;
        end
        S_ARMED: begin
          if (trig) state_nxt = (posttrig_q == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (remain == AW'(1)) state_nxt = S_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      decim_q    <= '0;
      posttrig_q <= '0;
      dec_cnt    <= '0;
      remain     <= '0;
      wr_ptr     <= '0;
      wrapped    <= 1'b0;
      trig_addr  <= '0;
    end else begin
      busy <= active;
      done <= (state == S_DONE);
      if (start) begin
        decim_q    <= decim;
        posttrig_q <= posttrig;
        dec_cnt    <= '0;
        wr_ptr     <= '0;
        wrapped    <= 1'b0;
        trig_addr  <= '0;
      end else if (active) begin
        dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DECW'(1);
        if (slot) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (state != S_FILL && last_addr) wrapped <= 1'b1;
          if (state == S_ARMED && trig) begin
            trig_addr <= wr_ptr;
            remain    <= posttrig_q;
          end
          if (state == S_POST) remain <= remain - AW'(1);
        end
      end
    end
  end

  // two-stage write pipeline keeps addr, data and we aligned
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      we       <= '0;
      addr     <= '0;
      data     <= '0;
    end else begin
      s1_valid <= slot;
      s1_addr  <= wr_ptr;
      s1_data  <= data_in;
      we       <= {NCH{s1_valid}};
      if (s1_valid) begin
        addr <= s1_addr;
        data <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_acqbuf_ctrl.sv
// tb/tb_acqbuf_ctrl.sv - self-checking bench for acqbuf_ctrl
// Capture runs are predicted from slot arithmetic over pre-generated stimulus arrays.
module tb_acqbuf_ctrl;

  localparam int NCH  = 2;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int DECW = 8;
  localparam int MAXC = 256;
  localparam int DEPTH = 1 << AW;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH*DW-1:0]   data_in;
  logic                start;
  logic                mode;
  logic                trig;
  logic [AW-1:0]       posttrig;
  logic [DECW-1:0]     decim;
  logic [AW-1:0]       addr;
  logic [NCH*DW-1:0]   data;
  logic [NCH-1:0]      we;
  logic                busy;
  logic                done;
  logic [AW-1:0]       trig_addr;
  logic                wrapped;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acqbuf_ctrl #(.NCH(NCH), .DW(DW), .AW(AW), .DECW(DECW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .start(start), .mode(mode),
    .trig(trig), .posttrig(posttrig), .decim(decim), .addr(addr), .data(data),
    .we(we), .busy(busy), .done(done), .trig_addr(trig_addr), .wrapped(wrapped)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " addr"}, addr, 0);
    chk({tag, " data"}, data, 0);
    chk({tag, " we"}, we, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " trig_addr"}, trig_addr, 0);
    chk({tag, " wrapped"}, wrapped, 0);
  endtask

  // cycle 0 of a run is the start cycle; slot j falls on cycle 1 + j*(decim+1)
  task automatic run_capture(input bit m, input int dc, input int pt, input int tslot,
                             input int tprob, input int abort_at,
                             output int got_n, output int got_done,
                             output int got_ta, output int got_wr);
    logic [NCH*DW-1:0] darr [MAXC];
    bit                tarr [MAXC];
    int                ec[$];
    int                ea[$];
    logic [NCH*DW-1:0] ed[$];
    int                n, jt, clast, wp, last_i;
    bit                expw;
    for (int c = 0; c < MAXC; c++) begin
      darr[c] = $urandom;
      tarr[c] = ($urandom_range(0, 99) < tprob);
    end
    if (tslot >= 0) begin
      for (int c = 0; c < MAXC; c++)
        tarr[c] = (c == 0) || (c == 1 + tslot * (dc + 1)) || ((c - 1) % (dc + 1) != 0);
    end else begin
      tarr[1 + 40 * (dc + 1)] = 1'b1;
    end
    jt = -1;
    if (m) begin
      for (int j = 0; j <= 40 && jt < 0; j++)
        if (tarr[1 + j * (dc + 1)]) jt = j;
      n = jt + 1 + pt;
    end else begin
      n = DEPTH;
    end
    for (int j = 0; j < n; j++) begin
      ec.push_back(1 + j * (dc + 1) + 2);
      ea.push_back(j % DEPTH);
      ed.push_back(darr[1 + j * (dc + 1)]);
    end
    clast  = 1 + (n - 1) * (dc + 1);
    last_i = (abort_at > 0) ? abort_at - 1 : clast + 4;
    wp = 0;
    got_done = -1;
    for (int i = 0; i <= last_i; i++) begin
      @(posedge clk);
      #1;
      start    = (i == 0);
      mode     = (i == 0) ? m : 1'($urandom);
      decim    = (i == 0) ? DECW'(dc) : DECW'($urandom);
      posttrig = (i == 0) ? AW'(pt) : AW'($urandom);
      data_in  = darr[i];
      trig     = tarr[i];
      @(negedge clk);
      if (i == 1) begin
        chk("trig_addr cleared by start", trig_addr, 0);
        chk("wrapped cleared by start", wrapped, 0);
      end
      if (i >= 2) begin
        expw = (wp < n) && (ec[wp] == i);
        chk($sformatf("we cyc%0d", i), we, {NCH{expw}});
        if (expw) begin
          chk($sformatf("addr wr%0d", wp), addr, ea[wp]);
          chk($sformatf("data wr%0d", wp), data, ed[wp]);
          wp++;
        end
        chk($sformatf("busy cyc%0d", i), busy, (i <= clast + 1));
        chk($sformatf("done cyc%0d", i), done, (i > clast + 1));
        if (done && got_done < 0) got_done = i;
      end
    end
    start = 1'b0;
    trig  = 1'b0;
    if (abort_at == 0) begin
      chk("write count", wp, n);
      chk("done cycle", got_done, clast + 2);
      chk("addr held", addr, (n - 1) % DEPTH);
      chk("trig_addr final", trig_addr, m ? jt % DEPTH : 0);
      chk("wrapped final", wrapped, (m && n >= DEPTH));
    end
    got_n  = wp;
    got_ta = int'(trig_addr);
    got_wr = int'(wrapped);
  endtask

  typedef struct {
    bit m;
    int dc;
    int pt;
    int ts;
    int tp;
    int xn;
    int xta;
    int xwr;
    int xdone;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int gn, gd, gta, gwr;
    vecs[0] = '{1'b0, 0, 0,  -1, 50, 16, 0, 0, 18};
    vecs[1] = '{1'b0, 2, 0,  -1, 0,  16, 0, 0, 48};
    vecs[2] = '{1'b1, 0, 5,  19, 0,  25, 3, 1, 27};
    vecs[3] = '{1'b1, 0, 0,  0,  0,  1,  0, 0, 3};
    vecs[4] = '{1'b1, 1, 15, 3,  0,  19, 3, 1, 39};
    vecs[5] = '{1'b1, 3, 2,  20, 0,  23, 4, 1, 91};

    reset = 1'b0; start = 1'b0; mode = 1'b0; trig = 1'b0;
    posttrig = '0; decim = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("after reset");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 data_in = $urandom; trig = 1'b1;
      @(negedge clk);
      chk("idle we", we, 0);
      chk("idle busy", busy, 0);
    end
    trig = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_capture(vecs[v].m, vecs[v].dc, vecs[v].pt, vecs[v].ts, vecs[v].tp, 0,
                  gn, gd, gta, gwr);
      chk($sformatf("vec%0d writes", v), gn, vecs[v].xn);
      chk($sformatf("vec%0d done cycle", v), gd, vecs[v].xdone);
      chk($sformatf("vec%0d trig_addr", v), gta, vecs[v].xta);
      chk($sformatf("vec%0d wrapped", v), gwr, vecs[v].xwr);
    end

    // restart while in POST after a wrap
    run_capture(1'b1, 0, 10, 17, 0, 22, gn, gd, gta, gwr);
    chk("pre-restart wrapped", wrapped, 1);
    chk("pre-restart trig_addr", trig_addr, 1);
    run_capture(1'b0, 0, 0, -1, 30, 0, gn, gd, gta, gwr);

    // reset in the middle of a fill, with start asserted during reset
    run_capture(1'b0, 0, 0, -1, 0, 7, gn, gd, gta, gwr);
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b1; mode = 1'b0; trig = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1; start = 1'b0; trig = 1'b0;
    @(negedge clk);
    chk_zero_outputs("mid-fill reset");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 data_in = $urandom;
      @(negedge clk);
      chk("post-reset we", we, 0);
      chk("post-reset busy", busy, 0);
      chk("post-reset done", done, 0);
    end

    for (int r = 0; r < 12; r++) begin
      bit rm;
      rm = 1'($urandom_range(0, 1));
      run_capture(rm, $urandom_range(0, 3), $urandom_range(0, 15), -1, rm ? 3 : 30, 0,
                  gn, gd, gta, gwr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
